// File: rtl/cdb_rx_link_ctrl.sv
// Receive-side link activation controller: STOP/ACT/RUN/DEACT handshake with per-channel credit gating.
// Define DSU_CDB_LINK_TIMEOUT_EN to build in the bounded DEACT wait and sticky timeout flag.
module cdb_rx_link_ctrl #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned ACT_DLY       = 2,
    parameter int unsigned DEACT_TIMEOUT = 1024
) (
    input  logic              clk_in,
    input  logic              rstn_in,
    input  logic              rx_linkactivereq,
    input  logic              sw_link_en,
    input  logic [NUM_CH-1:0] rxcrd_full,
    output logic              rx_linkactiveack,
    output logic [NUM_CH-1:0] en_crdv,
    output logic [1:0]        link_state,
    output logic              deact_timeout_err
);

    typedef enum logic [1:0] {
        StStop  = 2'b00,
        StAct   = 2'b01,
        StRun   = 2'b10,
        StDeact = 2'b11
    } link_state_e;

    localparam logic [3:0] ActLast = 4'(ACT_DLY - 1);

    link_state_e state_q, state_d;
    logic        ack_q, ack_d;
    logic [3:0]  act_cnt_q, act_cnt_d;

    logic link_up;
    logic all_full;
    logic act_done;
    logic deact_timeout;

    assign link_up  = rx_linkactivereq & sw_link_en;
    assign all_full = &rxcrd_full;
    assign act_done = (act_cnt_q == ActLast);

`ifdef DSU_CDB_LINK_TIMEOUT_EN
    localparam logic [15:0] DeactLast = 16'(DEACT_TIMEOUT - 1);

    logic [15:0] deact_cnt_q, deact_cnt_d;
    logic        err_q, err_d;

    assign deact_timeout = (state_q == StDeact) && !all_full && (deact_cnt_q == DeactLast);

    // Held at zero outside DEACT so it always starts from zero on entry.
    always_comb begin
        deact_cnt_d = '0;
        if (state_q == StDeact) begin
            deact_cnt_d = deact_cnt_q + 16'd1;
        end
        err_d = err_q | deact_timeout;
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            deact_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            deact_cnt_q <= deact_cnt_d;
            err_q       <= err_d;
        end
    end

    assign deact_timeout_err = err_q;
`else
    logic unused_deact_timeout;

    assign unused_deact_timeout = ^16'(DEACT_TIMEOUT);
    assign deact_timeout        = 1'b0;
    assign deact_timeout_err    = 1'b0;
`endif

    // ACT runs to completion regardless of the inputs; RUN then drops out a cycle later.
    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        act_cnt_d = act_cnt_q;
        unique case (state_q)
            StStop: begin
                if (link_up) begin
                    state_d   = StAct;
                    act_cnt_d = '0;
                end
            end
            StAct: begin
                act_cnt_d = act_cnt_q + 4'd1;
                if (act_done) begin
                    state_d = StRun;
                    ack_d   = 1'b1;
                end
            end
            StRun: begin
                if (!link_up) begin
                    state_d = StDeact;
                end
            end
            StDeact: begin
                if (all_full || deact_timeout) begin
                    state_d = StStop;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = StStop;
                ack_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q   <= StStop;
            ack_q     <= 1'b0;
            act_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            act_cnt_q <= act_cnt_d;
        end
    end

    assign rx_linkactiveack = ack_q;
    assign link_state       = state_q;
    assign en_crdv          = {NUM_CH{state_q == StRun}};

endmodule

// File: tb/tb_cdb_rx_link_ctrl.sv
// Bench for cdb_rx_link_ctrl: directed link sequences checked against a cycle-stamped state model.
module tb_cdb_rx_link_ctrl;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned ACT_DLY  = 2;
    localparam int unsigned TIMEOUT  = 8;
`ifdef DSU_CDB_LINK_TIMEOUT_EN
    localparam bit          TO_EN    = 1'b1;
    localparam int          WAIT_CYC = 5;
`else
    localparam bit          TO_EN    = 1'b0;
    localparam int          WAIT_CYC = 10;
`endif

    localparam int S_STOP  = 0;
    localparam int S_ACT   = 1;
    localparam int S_RUN   = 2;
    localparam int S_DEACT = 3;

    logic              clk_in = 1'b0;
    logic              rstn_in = 1'b0;
    logic              rx_linkactivereq = 1'b0;
    logic              sw_link_en = 1'b0;
    logic [NUM_CH-1:0] rxcrd_full = '0;
    logic              rx_linkactiveack;
    logic [NUM_CH-1:0] en_crdv;
    logic [1:0]        link_state;
    logic              deact_timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    cdb_rx_link_ctrl #(
        .NUM_CH        (NUM_CH),
        .ACT_DLY       (ACT_DLY),
        .DEACT_TIMEOUT (TIMEOUT)
    ) dut (
        .clk_in            (clk_in),
        .rstn_in           (rstn_in),
        .rx_linkactivereq  (rx_linkactivereq),
        .sw_link_en        (sw_link_en),
        .rxcrd_full        (rxcrd_full),
        .rx_linkactiveack  (rx_linkactiveack),
        .en_crdv           (en_crdv),
        .link_state        (link_state),
        .deact_timeout_err (deact_timeout_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // Model: state plus number of cycles already spent in it; outputs follow from the state.
    int m_state = S_STOP;
    int m_since = 0;
    bit m_err   = 1'b0;

    function automatic int model_next(input int st, input int since, input bit req, input bit en,
                                      input bit full);
        int nxt;
        nxt = st;
        case (st)
            S_STOP:  if (req && en) nxt = S_ACT;
            S_ACT:   if (since == int'(ACT_DLY) - 1) nxt = S_RUN;
            S_RUN:   if (!(req && en)) nxt = S_DEACT;
            default: begin
                if (full) nxt = S_STOP;
                else if (TO_EN && since == int'(TIMEOUT) - 1) nxt = S_STOP;
            end
        endcase
        return nxt;
    endfunction

    always @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            m_state <= S_STOP;
            m_since <= 0;
            m_err   <= 1'b0;
        end else begin
            int nxt;
            nxt = model_next(m_state, m_since, rx_linkactivereq, sw_link_en, &rxcrd_full);
            m_since <= (nxt == m_state) ? m_since + 1 : 0;
            m_state <= nxt;
            if (m_state == S_DEACT && nxt == S_STOP && !(&rxcrd_full)) m_err <= 1'b1;
        end
    end

    always @(negedge clk_in) begin
        check("model_state", 32'(link_state), 32'(m_state));
        check("model_ack", 32'(rx_linkactiveack),
              32'(m_state == S_RUN || m_state == S_DEACT));
        check("model_en_crdv", 32'(en_crdv), (m_state == S_RUN) ? 32'hF : 32'h0);
        check("model_err", 32'(deact_timeout_err), 32'(m_err));
    end

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic expect_out(input string name, input logic [1:0] st, input logic ack,
                              input logic [3:0] en);
        check({name, "_state"}, 32'(link_state), 32'(st));
        check({name, "_ack"}, 32'(rx_linkactiveack), 32'(ack));
        check({name, "_en_crdv"}, 32'(en_crdv), 32'(en));
    endtask

    task automatic activate(input string name);
        rx_linkactivereq = 1'b1;
        sw_link_en       = 1'b1;
        tick();
        expect_out({name, "_c1"}, 2'b01, 1'b0, 4'h0);
        tick();
        expect_out({name, "_c2"}, 2'b01, 1'b0, 4'h0);
        tick();
        expect_out({name, "_c3"}, 2'b10, 1'b1, 4'hF);
    endtask

    initial begin
        #1;
        expect_out("reset_held", 2'b00, 1'b0, 4'h0);
        check("reset_err", 32'(deact_timeout_err), 32'h0);
        tick();
        tick();
        rstn_in = 1'b1;
        rxcrd_full = 4'hF;
        tick();
        expect_out("post_reset", 2'b00, 1'b0, 4'h0);

        // Software permit low blocks activation.
        rx_linkactivereq = 1'b1;
        sw_link_en       = 1'b0;
        tick();
        tick();
        expect_out("sw_block", 2'b00, 1'b0, 4'h0);

        activate("act1");
        tick();
        expect_out("run_hold", 2'b10, 1'b1, 4'hF);

        // Clean deactivation with all credits home.
        rx_linkactivereq = 1'b0;
        tick();
        expect_out("deact_clean", 2'b11, 1'b1, 4'h0);
        tick();
        expect_out("stop_clean", 2'b00, 1'b0, 4'h0);

        // Credit wait in DEACT.
        activate("act2");
        rx_linkactivereq = 1'b0;
        rxcrd_full       = 4'b0111;
        for (int i = 0; i < WAIT_CYC; i++) begin
            tick();
            expect_out("credit_wait", 2'b11, 1'b1, 4'h0);
        end
        rxcrd_full = 4'hF;
        tick();
        expect_out("credit_done", 2'b00, 1'b0, 4'h0);

        // Abort during ACT still completes activation.
        rx_linkactivereq = 1'b1;
        tick();
        expect_out("abort_c1", 2'b01, 1'b0, 4'h0);
        tick();
        rx_linkactivereq = 1'b0;
        tick();
        expect_out("abort_c3", 2'b10, 1'b1, 4'hF);
        tick();
        expect_out("abort_c4", 2'b11, 1'b1, 4'h0);
        tick();
        expect_out("abort_stop", 2'b00, 1'b0, 4'h0);

        // Simultaneous drop of request and permit, then re-request while credits drain.
        activate("act3");
        rx_linkactivereq = 1'b0;
        sw_link_en       = 1'b0;
        rxcrd_full       = 4'b0111;
        tick();
        expect_out("dual_drop", 2'b11, 1'b1, 4'h0);
        rx_linkactivereq = 1'b1;
        sw_link_en       = 1'b1;
        tick();
        expect_out("rereq_wait", 2'b11, 1'b1, 4'h0);
        rxcrd_full = 4'hF;
        tick();
        expect_out("rereq_stop", 2'b00, 1'b0, 4'h0);
        tick();
        expect_out("rereq_act", 2'b01, 1'b0, 4'h0);
        tick();
        tick();
        expect_out("rereq_run", 2'b10, 1'b1, 4'hF);

        // Asynchronous reset from RUN, away from any rising edge.
        #2 rstn_in = 1'b0;
        #1;
        expect_out("async_reset", 2'b00, 1'b0, 4'h0);
        @(negedge clk_in);
        rx_linkactivereq = 1'b0;
        rstn_in          = 1'b1;
        tick();
        expect_out("after_reset", 2'b00, 1'b0, 4'h0);

        // DEACT with no credits returned.
        activate("act4");
        rx_linkactivereq = 1'b0;
        rxcrd_full       = 4'h0;
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            tick();
            expect_out("to_wait", 2'b11, 1'b1, 4'h0);
            check("to_err_low", 32'(deact_timeout_err), 32'h0);
        end
        tick();
`ifdef DSU_CDB_LINK_TIMEOUT_EN
        expect_out("to_fire", 2'b00, 1'b0, 4'h0);
        check("to_err_set", 32'(deact_timeout_err), 32'h1);
        rxcrd_full = 4'hF;
        activate("act5");
        check("to_err_sticky", 32'(deact_timeout_err), 32'h1);
`else
        for (int i = 0; i < 12; i++) begin
            tick();
            expect_out("no_to_wait", 2'b11, 1'b1, 4'h0);
            check("no_to_err", 32'(deact_timeout_err), 32'h0);
        end
        rxcrd_full = 4'hF;
        tick();
        expect_out("no_to_stop", 2'b00, 1'b0, 4'h0);
`endif
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
